// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexes one shared BCD-to-7-segment decoder across
// NUM_DIGITS common-cathode digits. A display register swaps in a new value
// only at frame boundaries, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   wr_valid  write request
//   wr_ready  write port can accept (pending slot empty), combinational
//   wr_data   packed BCD value, nibble i = digit i, nibble 0 least significant
//   lz_blank  1 = suppress leading zeros
//   bcd_out   registered nibble to shared decoder, 4'hF = blank
//   dig_en    registered one-hot digit enable, all-zero during guard/reset
module sevenseg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 1000,
  parameter int unsigned GUARD      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    lz_blank,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   dig_en
);

  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CMAX_A = (PRESCALE > GUARD) ? PRESCALE : GUARD;
  localparam int unsigned CMAX = (CMAX_A > 2) ? CMAX_A : 2;
  localparam int unsigned CW = $clog2(CMAX);
  localparam int unsigned GUARD_LAST = (GUARD > 0) ? GUARD - 1 : 0;

  localparam logic [0:0] S_SHOW  = 1'b0;
  localparam logic [0:0] S_GUARD = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW-1:0] disp_q, disp_d;
  logic [DW-1:0] pend_q, pend_d;
  logic          pend_full_q, pend_full_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [3:0]    bcd_q, bcd_d;

  logic          advance;
  logic          boundary;
  logic [3:0]    nib;
  logic          zero_up;

  assign wr_ready = ~pend_full_q;
  assign dig_en   = dig_en_q;
  assign bcd_out  = bcd_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_SHOW;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      dig_en_q    <= '0;
      bcd_q       <= 4'hF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      dig_en_q    <= dig_en_d;
      bcd_q       <= bcd_d;
    end
  end

  // Scan sequencing, write handshake, frame-boundary swap and digit output
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    dig_en_d    = '0;
    bcd_d       = 4'hF;
    advance     = 1'b0;
    boundary    = 1'b0;
    nib         = 4'h0;
    zero_up     = 1'b0;

    case (state_q)
      S_SHOW: begin
        if (cnt_q == CW'(PRESCALE - 1)) begin
          cnt_d = '0;
          if (GUARD > 0) state_d = S_GUARD;
          else           advance = 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == CW'(GUARD_LAST)) begin
          cnt_d   = '0;
          state_d = S_SHOW;
          advance = 1'b1;
        end
      end
      default: begin
        state_d = S_SHOW;
        cnt_d   = '0;
      end
    endcase

    if (advance) begin
      if (idx_q == IW'(NUM_DIGITS - 1)) begin
        idx_d    = '0;
        boundary = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Swap takes priority; a write can only land while the slot is empty,
    // so a capture on the boundary cycle waits for the next frame.
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
    end else if (wr_valid && !pend_full_q) begin
      pend_d      = wr_data;
      pend_full_d = 1'b1;
    end

    // zero_up: this nibble and every more-significant nibble are zero
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = disp_q[4*i +: 4];
        zero_up = ((disp_q >> (4*i)) == '0);
      end
    end

    if (state_q == S_SHOW) begin
      dig_en_d = NUM_DIGITS'(1) << idx_q;
      bcd_d    = (lz_blank && (idx_q != '0) && zero_up) ? 4'hF : nib;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized self-checking bench for sevenseg_scan against a position-in-frame
// reference model (NUM_DIGITS=4, PRESCALE=4, GUARD=1, frame = 20 cycles).
module tb_sevenseg_scan;

  localparam int ND    = 4;
  localparam int P     = 4;
  localparam int G     = 1;
  localparam int SLOT  = P + G;
  localparam int FRAME = ND * SLOT;
  localparam int NCYC  = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [4*ND-1:0] wr_data;
  logic          lz_blank;
  logic [3:0]    bcd_out;
  logic [ND-1:0] dig_en;

  int errors = 0;
  int checks = 0;

  sevenseg_scan #(.NUM_DIGITS(ND), .PRESCALE(P), .GUARD(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .lz_blank (lz_blank),
    .bcd_out  (bcd_out),
    .dig_en   (dig_en)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state: cycles since reset, shown value, pending slot
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;
  logic [3:0]  e_en;
  logic [3:0]  e_bcd;
  bit          accepted;
  logic [15:0] pick_tab [8];

  initial begin
    pick_tab[0] = 16'h1234; pick_tab[1] = 16'h0050;
    pick_tab[2] = 16'h0000; pick_tab[3] = 16'h9A00;
    pick_tab[4] = 16'h1111; pick_tab[5] = 16'h2222;
    pick_tab[6] = 16'h0000; pick_tab[7] = 16'h0000;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; lz_blank = 1'b1;
    t = 0; m_disp = '0; m_pend = '0; m_full = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Input drive: requester holds data while waiting for ready
      rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
      if (!wr_valid && ($urandom_range(0, 3) == 0)) begin
        int k;
        k = $urandom_range(0, 7);
        wr_valid = 1'b1;
        wr_data  = (k >= 6) ? 16'($urandom) : pick_tab[k];
      end
      if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;

      if (cyc >= 1) check("wr_ready", 32'(wr_ready), 32'(!m_full));

      @(posedge clk);
      accepted = 1'b0;
      if (rst) begin
        t = 0; m_disp = '0; m_full = 1'b0;
        e_en = '0; e_bcd = 4'hF;
      end else begin
        int pos, d, off;
        pos = t % FRAME;
        d   = pos / SLOT;
        off = pos % SLOT;
        if (off < P) begin
          logic [3:0] nb;
          nb   = 4'((m_disp >> (4*d)) & 16'hF);
          e_en = 4'(1 << d);
          if (lz_blank && d > 0 && (m_disp >> (4*d)) == 16'h0) e_bcd = 4'hF;
          else e_bcd = nb;
        end else begin
          e_en = '0; e_bcd = 4'hF;
        end
        if (((t + 1) % FRAME == 0) && m_full) begin
          m_disp = m_pend; m_full = 1'b0;
        end else if (wr_valid && !m_full) begin
          m_pend = wr_data; m_full = 1'b1; accepted = 1'b1;
        end
        t++;
      end

      #1;
      check("dig_en", 32'(dig_en), 32'(e_en));
      check("bcd_out", 32'(bcd_out), 32'(e_bcd));
      check("onehot", 32'($countones(dig_en) <= 1), 32'(1));
      if (accepted || rst) wr_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
- Time-multiplexes one shared BCD-to-7-segment decoder across NUM_DIGITS common-cathode digits.
- Holds a display register that is updated through a valid/ready write port. New values swap in only at frame boundaries, so a frame never mixes old and new digits.
- Per digit: selects the nibble, applies optional leading-zero blanking and drives a one-hot digit enable. A guard gap between digits prevents ghosting.
- Sits between the LC3 output path and the board display; bcd_out feeds sevenseg.in directly.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
PRESCALE, 1000, clock cycles each digit is lit (>=1)
GUARD, 1, clock cycles all digits dark between digits (>=0; 0 = no gap)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wr_valid  input  1  write request
wr_ready  output  1  write port can accept (pending slot empty)
wr_data  input  4*NUM_DIGITS  packed BCD value; nibble i = digit i, nibble 0 least significant
lz_blank  input  1  1 = suppress leading zeros
bcd_out  output  4  nibble to shared decoder; 4'hF = blank (decoder emits all-off)
dig_en  output  NUM_DIGITS  one-hot active-high digit enable; all-zero during guard/reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on rising clk.
- Reset values:
  - Registered outputs: dig_en=0, bcd_out=4'hF.
  - Internal state: disp_reg=0, pending empty, idx=0, state=SHOW, cnt=0.
  - wr_ready=1 on the first cycle after reset.
  - Reset asserted mid-frame aborts the scan and discards the pending value.
- State machine: SHOW, GUARD.
  - SHOW: cnt counts 0..PRESCALE-1. At PRESCALE-1, cnt clears. Go to GUARD if GUARD>0; otherwise advance idx and stay in SHOW.
  - GUARD: cnt counts 0..GUARD-1. At GUARD-1, cnt clears, idx advances, return to SHOW.
  - idx advance: idx+1, wrapping NUM_DIGITS-1 -> 0.
  - Counter width: $clog2 of max(PRESCALE,GUARD,2).
- Frame:
  - Frame length = NUM_DIGITS*(PRESCALE+GUARD) cycles.
  - Frame boundary = the cycle idx wraps to 0.
  - At the boundary, if pending is full: disp_reg<=pending, pending empties.
- Write handshake:
  - wr_ready = pending empty; combinational from the register state.
  - Transfer occurs when wr_valid && wr_ready: wr_data is captured into pending.
  - A transfer on the boundary cycle itself lands in pending and is shown from the following frame, never the current one.
  - wr_valid held while not ready: no capture; the requester must hold wr_data stable.
  - After a swap, wr_ready rises on the next cycle.
- Digit output, computed from state/idx/disp_reg and registered (1-cycle latency):
  - In SHOW, dig_en = one-hot(idx).
  - In GUARD, dig_en = 0 and bcd_out = 4'hF.
  - nibble = disp_reg[4*idx +: 4].
  - Leading-zero blank: if lz_blank=1, idx>0, and nibble and every more-significant nibble == 0, bcd_out = 4'hF; otherwise bcd_out = nibble.
  - Digit 0 is never blanked.
  - A nibble >9 counts as nonzero for blanking and passes through unchanged; the decoder renders it dark.
  - lz_blank may change at any time; it takes effect on the next registered output.
- Invariant: at most one dig_en bit set in any cycle.

Test Plan:
- NUM_DIGITS=4, PRESCALE=4, GUARD=1 (frame=20 cycles). Release reset -> dig_en=0001 for cycles 1-4 after release, 0000 for cycle 5, 0010 for cycles 6-9; bcd_out=0 on digit 0; wr_ready=1.
- Write 0x1234 mid-frame -> wr_ready low next cycle. Digits show 0 until the frame boundary. Next frame, bcd_out sequence per digit 0..3 = 4,3,2,1. wr_ready returns high the cycle after the swap.
- Write 0x0050 with lz_blank=1 -> bcd_out per digit = 0,5,F,F. With lz_blank=0 -> 0,5,0,0. Value 0x0000 with lz_blank=1 -> 0,F,F,F.
- Back-to-back writes: 0x1111 accepted; 0x2222 held with wr_valid while wr_ready=0 -> 0x1111 shown for a full frame. 0x2222 is accepted right after the swap and shown the frame after. No frame mixes nibbles.
- Write 0x9A00 on the exact boundary cycle -> captured to pending, not displayed that frame. Next frame bcd_out = 0,0,A,9; digits 0/1 stay 0 despite lz_blank=1, because the nonzero nibble A sits above them.
- Assert rst for 1 cycle mid-SHOW of digit 2 with pending full -> next cycle dig_en=0, bcd_out=F. Scan restarts at digit 0 showing 0. Pending discarded; wr_ready=1.
